// File: rtl/ter_pkg.sv
// Shared ternary definitions for the mod-3 polynomial datapath.
// Provides the 2-bit ternary type, its three legal codes, the stream FSM state type,
// and a normalize helper that maps the illegal code 11 onto zero.
package ter_pkg;

  typedef logic [1:0] ter_t;

  localparam ter_t TER_ZERO = 2'b00;
  localparam ter_t TER_POS  = 2'b01;
  localparam ter_t TER_NEG  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  // Code 11 carries no meaning on the wire; it is read as zero.
  function automatic ter_t ter_norm(input ter_t c);
    return (c == 2'b11) ? TER_ZERO : c;
  endfunction

endpackage

// File: rtl/sub_ter.sv
// Ternary subtractor: z = x - y (mod 3), purely combinational.
// Ports: x, y - ternary operands (11 read as 0); z - ternary result, never 11.
// Latency: zero cycles; no flow control.
module sub_ter (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] z
);
  import ter_pkg::*;

  ter_t xn;
  ter_t yn;

  always_comb begin
    xn = ter_norm(x);
    yn = ter_norm(y);
    z  = TER_ZERO;
    // Differences of +/-2 wrap to -/+1 modulo 3.
    case ({xn, yn})
      {TER_ZERO, TER_POS}:  z = TER_NEG;
      {TER_ZERO, TER_NEG}:  z = TER_POS;
      {TER_POS,  TER_ZERO}: z = TER_POS;
      {TER_POS,  TER_NEG}:  z = TER_NEG;
      {TER_NEG,  TER_ZERO}: z = TER_NEG;
      {TER_NEG,  TER_POS}:  z = TER_POS;
      default:              z = TER_ZERO;
    endcase
  end

endmodule

// File: rtl/mul_phi1_stream.sv
// Streaming multiply by (x-1) in Z3[x]/(x^N-1): b_i = a_(i-1) - a_i, two coefs per beat.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_coef input stream;
//        out_valid/out_ready/out_coef/out_lanes/out_last output stream (one register, 1-cycle latency).
// Backpressure: in_ready follows output-register availability; one extra tail beat (b_0) per polynomial.
module mul_phi1_stream #(
  parameter int N = 701
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_coef,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_coef,
  output logic [1:0] out_lanes,
  output logic       out_last
);
  import ter_pkg::*;

  localparam int              CW        = $clog2((N + 1) / 2);
  localparam logic [CW-1:0]   LAST_BEAT = CW'((N - 1) / 2);

  if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
    $error("mul_phi1_stream: N must be odd and >= 3");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ter_t          prev_q, prev_d;    // last coef seen: a_(2k-1) in RUN, a_(N-1) in TAIL
  ter_t          first_q, first_d;  // a_0, needed again for the wrap-around b_0
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_coef_q, out_coef_d;
  logic [1:0]    out_lanes_q, out_lanes_d;
  logic          out_last_q, out_last_d;

  ter_t a_lo;
  ter_t a_hi;
  ter_t d_lane0;
  ter_t d_lane1;
  ter_t d_tail;
  logic out_free;
  logic in_fire;
  logic tail_load;

  assign a_lo = ter_norm(in_coef[1:0]);
  assign a_hi = ter_norm(in_coef[3:2]);

  // lane0: b_2k = a_(2k-1) - a_2k
  sub_ter u_lane0 (.x(prev_q), .y(a_lo),    .z(d_lane0));
  // lane1: b_2k+1 = a_2k - a_2k+1
  sub_ter u_lane1 (.x(a_lo),   .y(a_hi),    .z(d_lane1));
  // tail: b_0 = a_(N-1) - a_0
  sub_ter u_tail  (.x(prev_q), .y(first_q), .z(d_tail));

  // Output register can take a new beat when empty or being drained this cycle.
  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && out_free;
  assign in_fire   = in_valid && in_ready;
  assign tail_load = (state_q == ST_TAIL) && out_free;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      if (cnt_q == '0) begin
        // Beat 0: b_0 needs a_(N-1), so only b_1 can be produced now.
        out_coef_d  = {d_lane1, TER_ZERO};
        out_lanes_d = 2'b10;
        first_d     = a_lo;
        prev_d      = a_hi;
        cnt_d       = cnt_q + CW'(1);
      end else if (cnt_q == LAST_BEAT) begin
        // Final beat carries a_(N-1) alone; lane1 input is ignored.
        out_coef_d  = {TER_ZERO, d_lane0};
        out_lanes_d = 2'b01;
        prev_d      = a_lo;
        cnt_d       = '0;
        state_d     = ST_TAIL;
      end else begin
        out_coef_d  = {d_lane1, d_lane0};
        out_lanes_d = 2'b11;
        prev_d      = a_hi;
        cnt_d       = cnt_q + CW'(1);
      end
    end else if (tail_load) begin
      out_valid_d = 1'b1;
      out_coef_d  = {TER_ZERO, d_tail};
      out_lanes_d = 2'b01;
      out_last_d  = 1'b1;
      state_d     = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      prev_q      <= TER_ZERO;
      first_q     <= TER_ZERO;
      out_valid_q <= 1'b0;
      out_coef_q  <= 4'b0000;
      out_lanes_q <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_coef  = out_coef_q;
  assign out_lanes = out_lanes_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mul_phi1_stream.sv
// Testbench for mul_phi1_stream: directed and random polynomials against a whole-polynomial model.
// Expected beats are derived from b_i = a_(i-1) - a_i over the full polynomial, then queued.
// Output beats are popped and compared on every handshake; stalls are checked for stability.
module tb_mul_phi1_stream;

  localparam int N  = 701;
  localparam int NB = (N + 1) / 2;

  typedef struct packed {
    logic [3:0] coef;
    logic [1:0] lanes;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_coef;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_coef;
  logic [1:0] out_lanes;
  logic       out_last;

  int checks = 0;
  int errors = 0;
  int n_last = 0;
  int cyc    = 0;

  beat_t      exp_q[$];
  beat_t      model_q[$];
  logic [1:0] poly [N];

  bit gap_en    = 1'b0;
  bit rdy_rand  = 1'b0;
  bit force_low = 1'b0;

  mul_phi1_stream #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_lanes (out_lanes),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int tval(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] enc(input int v);
    int m;
    m = ((v % 3) + 3) % 3;
    case (m)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Whole-polynomial reference: compute every b_i, then lay them out as output beats.
  task automatic build_model();
    int    b [N];
    beat_t e;
    model_q.delete();
    for (int i = 0; i < N; i++) b[i] = tval(poly[(i + N - 1) % N]) - tval(poly[i]);
    for (int k = 0; k < NB; k++) begin
      e.coef = 4'b0000;
      e.last = 1'b0;
      if (k == 0) begin
        e.coef[3:2] = enc(b[1]);
        e.lanes     = 2'b10;
      end else if (2 * k + 1 < N) begin
        e.coef  = {enc(b[2 * k + 1]), enc(b[2 * k])};
        e.lanes = 2'b11;
      end else begin
        e.coef[1:0] = enc(b[2 * k]);
        e.lanes     = 2'b01;
      end
      model_q.push_back(e);
    end
    e.coef  = {2'b00, enc(b[0])};
    e.lanes = 2'b01;
    e.last  = 1'b1;
    model_q.push_back(e);
  endtask

  task automatic send_beat(input logic [3:0] c);
    int guard;
    guard = 0;
    if (gap_en) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_coef  = c;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 2000) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Queues the current model, then sends the first nbeats input beats of poly.
  task automatic send_poly(input int nbeats);
    logic [1:0] hi;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    for (int k = 0; k < nbeats; k++) begin
      if (2 * k + 1 < N) hi = poly[2 * k + 1];
      else               hi = 2'($urandom_range(0, 3));
      send_beat({hi, poly[2 * k]});
    end
  endtask

  task automatic rand_poly();
    for (int i = 0; i < N; i++) poly[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic zero_poly();
    for (int i = 0; i < N; i++) poly[i] = 2'b00;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = force_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Compare process: checks every accepted output beat and stall stability.
  bit         stall_prev = 1'b0;
  logic [3:0] sv_coef;
  logic [1:0] sv_lanes;
  logic       sv_last;
  beat_t      e_cur;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_coef",  32'(out_coef),  32'(sv_coef));
        chk("hold_lanes", 32'(out_lanes), 32'(sv_lanes));
        chk("hold_last",  32'(out_last),  32'(sv_last));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e_cur = exp_q.pop_front();
          chk("beat_coef",  32'(out_coef),  32'(e_cur.coef));
          chk("beat_lanes", 32'(out_lanes), 32'(e_cur.lanes));
          chk("beat_last",  32'(out_last),  32'(e_cur.last));
        end
        if (out_last) n_last++;
      end
      stall_prev = out_valid && !out_ready;
      sv_coef    = out_coef;
      sv_lanes   = out_lanes;
      sv_last    = out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int drain;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_coef  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_coef",  32'(out_coef),  32'd0);
    chk("rst_out_lanes", 32'(out_lanes), 32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // All-zero polynomial.
    zero_poly();
    build_model();
    chk("model_zero_len",   32'(model_q.size()), 32'd352);
    chk("model_zero_last",  32'(model_q[351].last), 32'd1);
    chk("model_zero_nolast", 32'(model_q[350].last), 32'd0);
    chk("model_zero_coef",  32'(model_q[100].coef), 32'd0);
    send_poly(NB);

    // a_0 = +1: b_1 = +1 in beat 0 lane1, b_0 = -1 on the tail.
    zero_poly();
    poly[0] = 2'b01;
    build_model();
    chk("model_a0_b1",    32'(model_q[0].coef),  32'h4);
    chk("model_a0_lanes", 32'(model_q[0].lanes), 32'h2);
    chk("model_a0_beat1", 32'(model_q[1].coef),  32'h0);
    chk("model_a0_tail",  32'(model_q[351].coef), 32'h2);
    c0 = cyc;
    send_poly(NB);
    chk("throughput_a0", 32'(cyc - c0), 32'(NB + 1));

    // a_700 = -1: b_700 = +1 in beat 350 lane0, b_0 = -1 on the tail.
    zero_poly();
    poly[700] = 2'b10;
    build_model();
    chk("model_a700_b700",  32'(model_q[350].coef),  32'h1);
    chk("model_a700_lanes", 32'(model_q[350].lanes), 32'h1);
    chk("model_a700_tail",  32'(model_q[351].coef),  32'h2);
    c0 = cyc;
    send_poly(NB);
    chk("throughput_a700", 32'(cyc - c0), 32'(NB + 1));

    // Five-cycle output stall in the middle of a polynomial.
    rand_poly();
    build_model();
    fork
      send_poly(NB);
      begin
        repeat (60) @(negedge clk);
        force_low = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("stall5_in_ready", 32'(in_ready), 32'd0);
        end
        force_low = 1'b0;
      end
    join

    // Reset after input beat 100, then a fresh polynomial.
    rand_poly();
    build_model();
    send_poly(101);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_lanes", 32'(out_lanes), 32'd0);
    rst = 1'b0;
    rand_poly();
    build_model();
    send_poly(NB);

    // Random back-to-back polynomials with random valid/ready.
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    repeat (3) begin
      rand_poly();
      build_model();
      send_poly(NB);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 4000) begin
      @(posedge clk);
      drain++;
    end
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("last_count",  32'(n_last),       32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_phi1_stream.md
MUL_PHI1_STREAM -- requirements
Module: mul_phi1_stream

Interface
REQ-001 Parameter N, default 701; polynomial length; SHALL be odd and >= 3.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input beat offered.
REQ-005 in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-006 in_coef  input  4  two ternary coefs; [1:0] lane0 = a_2k, [3:2] lane1 = a_2k+1 (ignored on final beat).
REQ-007 out_valid  output  1  output beat offered.
REQ-008 out_ready  input  1  output beat taken when out_valid & out_ready.
REQ-009 out_coef  output  4  two ternary result coefs, lane0 [1:0], lane1 [3:2].
REQ-010 out_lanes  output  2  per-lane valid mask (bit0 lane0, bit1 lane1).
REQ-011 out_last  output  1  marks final output beat of a polynomial.

Function
REQ-012 Computes b = a*(x-1) mod (x^N-1) mod 3: b_i = a_(i-1) - a_i, a_(-1) = a_(N-1).
REQ-013 Ternary encoding: 00 = 0, 01 = +1, 10 = -1; input 11 SHALL be treated as 0; outputs SHALL never be 11.
REQ-014 Input: (N+1)/2 beats per polynomial, beat k carries a_2k, a_2k+1; beat (N-1)/2 carries only a_(N-1) in lane0.
REQ-015 Beat counter 0..(N-1)/2; wraps to 0 after the final input beat.
REQ-016 Output beat 0: lane1 = b_1, out_lanes = 10; a_0 saved in first register.
REQ-017 Output beats 1..(N-3)/2: lane0 = b_2k (uses registered a_(2k-1)), lane1 = b_2k+1, out_lanes = 11.
REQ-018 Output beat (N-1)/2: lane0 = b_(N-1), out_lanes = 01.
REQ-019 Tail beat: lane0 = b_0 = a_(N-1) - a_0, out_lanes = 01, out_last = 1; out_last = 0 on all other beats.
REQ-020 FSM states RUN and TAIL; RUN -> TAIL on acceptance of final input beat; TAIL -> RUN when tail beat is loaded into the output register.
REQ-021 Single output register; latency one cycle from input acceptance to out_valid.
REQ-022 in_ready = (state == RUN) & (!out_valid | out_ready); in_ready = 0 in TAIL.
REQ-023 out_coef, out_lanes, out_last SHALL hold stable while out_valid & !out_ready.
REQ-024 Full throughput: back-to-back polynomials with a single-cycle bubble for the tail beat only.
REQ-025 Unused lanes (out_lanes bit 0) SHALL drive 00.

Reset
REQ-026 On rst: out_valid = 0, out_coef = 0, out_lanes = 0, out_last = 0, counter = 0, state = RUN, prev/first registers = 00.
REQ-027 rst mid-polynomial SHALL discard partial input and pending output; next accepted beat is beat 0.

Structure
REQ-028 Shared package ter_pkg: ter_t 2-bit typedef, constants TER_ZERO/TER_POS/TER_NEG, and a normalize function (11 -> 00).
REQ-029 One sub-module sub_ter (combinational z = x - y mod 3), instanced three times (two lanes plus tail).

Verification
REQ-030 All-zero input, N=701 -> 352 output beats, all coefs 00, out_last only on beat 351.
REQ-031 a_0 = +1, others 0 -> b_1 = +1 (beat 0 lane1), b_0 = -1 (tail), all others 00.
REQ-032 a_700 = -1, others 0 -> b_700 = +1 (beat 350 lane0), b_0 = -1 (tail).
REQ-033 out_ready held low 5 cycles mid-stream -> in_ready = 0, output fields stable, no beat lost or duplicated.
REQ-034 rst asserted after input beat 100 -> out_valid = 0 next cycle; fresh polynomial then yields correct result from beat 0.
REQ-035 Random polynomials back-to-back with random in_valid/out_ready -> matches reference model; input 11 treated as 0.
